down_timer: RTL and testbench
=============================

Name: down_timer

Overview:
- Loadable down-counting interval timer with borrow output; the decrementing counterpart of the team's up-counter with carry-out.
- Used in the function generator to time waveform segments and to produce periodic tick pulses from a programmed reload value.
- Supports one-shot and periodic (auto-reload) modes.
- Small FSM with start/stop control and a registered done pulse.

Parameters:
- N, 8, counter width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- reloadData  input  N  value loaded on start and on periodic reload.
- start  input  1  level-sampled each clock; loads reloadData and enters RUN.
- stop  input  1  aborts a run and returns to IDLE.
- periodic  input  1  1 = auto-reload at terminal count; 0 = one-shot. Sampled at terminal count.
- en  input  1  count enable / tick qualifier.
- out  output  N  current count value.
- bo  output  1  combinational borrow: busy & en & (out == 0).
- busy  output  1  high while in RUN.
- done  output  1  registered one-cycle pulse following each terminal count.

Behaviour:
- Reset values (asynchronous): out = 0, state = IDLE, busy = 0, done = 0. bo = 0 as a consequence.
- Clocked priority each edge: rst, then stop, then start, then count.
- IDLE:
  - out holds its value.
  - start=1 and reloadData != 0: out <= reloadData, go to RUN.
  - start=1 and reloadData == 0: stay in IDLE, out <= 0, done <= 1 on the next edge (zero-length interval).
- RUN, evaluated in order:
  - stop=1: go to IDLE, out holds its current value, no done.
  - start=1 (restart): out <= reloadData, stay in RUN. Prescaler is cleared if compiled in. No done.
  - en=1 and out != 0: out <= out - 1.
  - en=1 and out == 0 (bo=1): done <= 1.
    - periodic=1: out <= reloadData, stay in RUN.
    - periodic=0: go to IDLE, out stays 0.
  - en=0: hold.
- Timing:
  - Period in periodic mode is reloadData+1 qualified ticks.
  - bo is high for exactly one qualified tick per period.
  - done goes high on the edge that consumes bo and lasts one cycle.
  - done is low in every other cycle.
- Wrap-around: out never decrements below 0. No modular wrap from 0 to all-ones.
- Periodic reload with reloadData == 0 while in RUN: out stays 0 and bo/done fire on every qualified tick.
- reloadData changes mid-run take effect only at the next load or reload.
- start and stop in the same cycle: stop wins.
- rst asserted mid-run: immediate return to the reset values, independent of clk.
- Width: all arithmetic is N bits. The decrement is guarded, so there is no borrow propagation beyond the out == 0 check.

Optional Feature:
- Macro: DOWN_TIMER_PRESCALE_EN.
- When defined:
  - Adds parameter P (default 4, P >= 2) and an internal ceil(log2 P)-bit prescaler.
  - In RUN, the prescaler counts en cycles from 0 to P-1 and wraps.
  - The qualified tick is en & (prescaler == P-1). This tick replaces en in the decrement, the terminal count and bo.
  - Prescaler reset value is 0. It is cleared on start, on stop and on rst, and holds in IDLE.
- When undefined: qualified tick = en. There is no P parameter and no prescaler logic.

Test Plan:
- Reset: assert rst mid-simulation with no clk edge -> out=0, busy=0, done=0, bo=0 immediately.
- One-shot: reloadData=3, periodic=0, en=1, start pulsed one cycle -> out 3,2,1,0. bo=1 in the out=0 cycle, then IDLE with busy=0, done=1 for exactly one cycle, out stays 0.
- Periodic: reloadData=2, periodic=1, en=1 -> out 2,1,0,2,1,0,... bo and done each pulse once every 3 cycles, busy stays 1.
- Enable gating: reloadData=5, en toggled 1,0,0,1 -> out decrements only on en=1 cycles (5,4,4,4,3). bo never asserts while en=0.
- Stop/start conflict: at out=5 in RUN, assert start and stop together -> IDLE, out=5, busy=0, no done. A later start with reloadData=9 -> out=9, busy=1.
- Zero reload: start with reloadData=0 in IDLE -> stays IDLE, out=0, done pulses once, busy=0.
- With DOWN_TIMER_PRESCALE_EN and P=4: reloadData=1, en=1 -> out changes every 4 cycles. done fires 8 cycles after RUN entry.

Source files
------------

// File: rtl/down_timer.sv
// Loadable down-counting interval timer with borrow output, one-shot/periodic modes.
// Optional input prescaler enabled by defining DOWN_TIMER_PRESCALE_EN (adds parameter P).
module down_timer #(
    parameter int N = 8
`ifdef DOWN_TIMER_PRESCALE_EN
    , parameter int P = 4
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] reloadData,
    input  logic         start,
    input  logic         stop,
    input  logic         periodic,
    input  logic         en,
    output logic [N-1:0] out,
    output logic         bo,
    output logic         busy,
    output logic         done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state;
    logic   tick;

`ifdef DOWN_TIMER_PRESCALE_EN
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam logic [PW-1:0] PMAX = PW'(P - 1);

    logic [PW-1:0] pre;

    assign tick = en & (pre == PMAX);
`else
    assign tick = en;
`endif

    assign bo = busy & tick & (out == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef DOWN_TIMER_PRESCALE_EN
            pre   <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (stop) begin
                state <= IDLE;
                busy  <= 1'b0;
`ifdef DOWN_TIMER_PRESCALE_EN
                pre   <= '0;
`endif
            end else if (start) begin
`ifdef DOWN_TIMER_PRESCALE_EN
                pre <= '0;
`endif
                // A zero-length interval from IDLE completes at once; a restart in RUN always reloads.
                if (state == IDLE && reloadData == '0) begin
                    out  <= '0;
                    done <= 1'b1;
                end else begin
                    out   <= reloadData;
                    state <= RUN;
                    busy  <= 1'b1;
                end
            end else if (state == RUN) begin
`ifdef DOWN_TIMER_PRESCALE_EN
                if (en)
                    pre <= (pre == PMAX) ? '0 : pre + PW'(1);
`endif
                if (tick) begin
                    if (out != '0) begin
                        out <= out - N'(1);
                    end else begin
                        done <= 1'b1;
                        if (periodic) begin
                            out <= reloadData;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_down_timer.sv
// Randomized scoreboard bench for down_timer (default build, N = 8, no prescaler).
module tb_down_timer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] reloadData = '0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         periodic = 1'b0;
    logic         en = 1'b0;
    logic [N-1:0] out;
    logic         bo;
    logic         busy;
    logic         done;

    down_timer #(.N(N)) dut (
        .clk(clk), .rst(rst), .reloadData(reloadData), .start(start), .stop(stop),
        .periodic(periodic), .en(en), .out(out), .bo(bo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] out;
        logic         bo;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // Reference model: remaining count, running flag, pending completion pulse.
    int m_cnt = 0;
    bit m_run = 0;
    bit m_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_run = 0; m_done = 0;
    endtask

    task automatic model_step(input bit s, input bit p, input bit per, input bit e, input int rl);
        bit d = 0;
        if (p) begin
            m_run = 0;
        end else if (s) begin
            if (!m_run && rl == 0) begin
                m_cnt = 0; d = 1;
            end else begin
                m_cnt = rl; m_run = 1;
            end
        end else if (m_run && e) begin
            if (m_cnt > 0) m_cnt = m_cnt - 1;
            else begin
                d = 1;
                if (per) m_cnt = rl;
                else m_run = 0;
            end
        end
        m_done = d;
    endtask

    // One clock: advance the model across the edge, then apply new inputs and queue the expectation.
    task automatic cycle(input bit r, input bit s, input bit p, input bit per, input bit e, input int rl);
        exp_t x;
        @(posedge clk);
        if (rst) model_reset();
        else model_step(start, stop, periodic, en, int'(reloadData));
        #1;
        rst = r; start = s; stop = p; periodic = per; en = e; reloadData = N'(rl);
        if (r) begin
            model_reset();
            #1;
            chk("async_rst_out", 32'(out), 0);
            chk("async_rst_busy", 32'(busy), 0);
            chk("async_rst_done", 32'(done), 0);
            chk("async_rst_bo", 32'(bo), 0);
        end
        x.out  = N'(m_cnt);
        x.busy = m_run;
        x.done = m_done;
        x.bo   = m_run & e & (m_cnt == 0);
        q.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("out", 32'(out), 32'(x.out));
                chk("bo", 32'(bo), 32'(x.bo));
                chk("busy", 32'(busy), 32'(x.busy));
                chk("done", 32'(done), 32'(x.done));
            end
        end
    end

    initial begin : stim
        int per_r;
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        // one-shot
        cycle(0, 1, 0, 0, 1, 3);
        repeat (6) cycle(0, 0, 0, 0, 1, 3);
        // periodic
        cycle(0, 1, 0, 1, 1, 2);
        repeat (9) cycle(0, 0, 0, 1, 1, 2);
        cycle(0, 0, 1, 1, 1, 2);
        // enable gating
        cycle(0, 1, 0, 0, 1, 5);
        cycle(0, 0, 0, 0, 1, 5);
        cycle(0, 0, 0, 0, 0, 5);
        cycle(0, 0, 0, 0, 0, 5);
        cycle(0, 0, 0, 0, 1, 5);
        cycle(0, 0, 1, 0, 1, 5);
        // start/stop conflict at out=5, then fresh start with 9
        cycle(0, 1, 0, 0, 1, 7);
        cycle(0, 0, 0, 0, 1, 7);
        cycle(0, 0, 0, 0, 1, 7);
        cycle(0, 1, 1, 0, 1, 9);
        cycle(0, 0, 0, 0, 1, 9);
        cycle(0, 1, 0, 0, 0, 9);
        repeat (3) cycle(0, 0, 0, 0, 1, 9);
        cycle(0, 0, 1, 0, 0, 9);
        // zero reload from IDLE
        cycle(0, 1, 0, 0, 1, 0);
        repeat (3) cycle(0, 0, 0, 0, 1, 0);
        // periodic zero reload while running
        cycle(0, 1, 0, 1, 1, 2);
        cycle(0, 0, 0, 1, 1, 0);
        repeat (6) cycle(0, 0, 0, 1, 1, 0);
        // reset mid-run
        cycle(0, 1, 0, 0, 1, 200);
        repeat (3) cycle(0, 0, 0, 0, 1, 200);
        cycle(1, 0, 0, 0, 1, 200);
        cycle(0, 0, 0, 0, 1, 200);
        // randomized traffic
        per_r = 0;
        for (int i = 0; i < 3000; i++) begin
            int rl;
            if ($urandom_range(0, 49) == 0) per_r = int'($urandom_range(0, 1));
            rl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
            cycle(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 24) == 0),
                  per_r[0],
                  ($urandom_range(0, 3) != 0),
                  rl);
        end
        for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
